regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised successor to the core's integer register file: N synchronous read ports, one write port, and a per-register busy scoreboard for in-order pipeline hazard detection.
- Sits between decode/issue (reads, busy set) and writeback (writes, busy clear).
- Read data is registered and presented one cycle after the request, with write-to-read bypass.
- Register 0 is hardwired to zero.

Parameters:
BUS_DATA_WIDTH, 64, width of each register and data port
NUM_REGS, 32, number of architectural registers (power of two, >=2)
NUM_RD_PORTS, 2, number of independent read ports (1..4)
ADDR_W, $clog2(NUM_REGS), register index width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
rd_en  input  NUM_RD_PORTS  per-port read request
rd_addr  input  NUM_RD_PORTS*ADDR_W  packed read indices, port p at [p*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD_PORTS*BUS_DATA_WIDTH  packed registered read data
rd_valid  output  NUM_RD_PORTS  rd_data for port p is valid this cycle
rd_busy  output  NUM_RD_PORTS  registered busy status of the register read
wr_en  input  1  writeback strobe
wr_addr  input  ADDR_W  writeback index
wr_data  input  BUS_DATA_WIDTH  writeback value
sb_set_en  input  1  issue marks destination register pending
sb_set_addr  input  ADDR_W  destination index to mark busy
busy_vec  output  NUM_REGS  live scoreboard, bit i = register i pending

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - all registers cleared to 0
  - busy_vec = 0
  - rd_data = 0, rd_valid = 0, rd_busy = 0
- Read, 1-cycle latency: rd_en[p] sampled at edge k produces the following at edge k+1:
  - rd_valid[p] = 1
  - rd_data[p] = contents of rd_addr[p]
  - rd_busy[p] = busy state of that register after edge k's scoreboard update
- rd_en[p] = 0 at edge k:
  - rd_valid[p] = 0 at edge k+1
  - rd_data[p] and rd_busy[p] hold their previous values.
- Bypass: if wr_en && wr_addr == rd_addr[p] && wr_addr != 0 in the same cycle, rd_data[p] returns wr_data (write-first). This applies independently on every port.
- Register 0:
  - reads always return 0 with rd_busy 0
  - writes to index 0 are dropped
  - sb_set_en to index 0 is ignored
  - busy_vec[0] is always 0
- Write: wr_en updates mem[wr_addr] at the rising edge. One write per cycle.
- Scoreboard, per register i at each edge:
  - set when sb_set_en && sb_set_addr == i
  - cleared when wr_en && wr_addr == i
  - both on the same i in the same cycle: set wins (a new producer was issued while the old one retires); data is still written.
  - neither: hold.
- busy_vec reflects registered state, with no combinational path from inputs.
- Out-of-range indices cannot occur because NUM_REGS is a power of two.
- Reset asserted mid-operation: all state is cleared immediately. Pending reads are discarded, with rd_valid forced to 0 asynchronously.

Decomposition:
- Shared package regfile_pkg holds:
  - reg_idx_t typedef (ADDR_W bits)
  - constant REG_ZERO = 0
  - default width/depth constants shared with decode and writeback.
- One natural sub-module, regfile_read_port: a single registered read port containing the bypass mux, zero forcing, and the valid/busy pipeline register. It is instantiated NUM_RD_PORTS times in a generate loop.
- Storage array and scoreboard stay in the top module.

Test Plan:
- Reset then read every index on all ports -> rd_data = 0, rd_busy = 0, rd_valid high exactly one cycle after each rd_en.
- Write 0xDEADBEEF_CAFEF00D to r5, read r5 on port 0 next cycle -> rd_data[0] = 0xDEADBEEF_CAFEF00D one cycle after rd_en.
- Same-cycle wr_en to r7 = 0x1234 and rd_en r7 on ports 0 and 1 -> both ports return 0x1234 (bypass).
- Write 0xFFFF to r0, sb_set_en r0, then read r0 -> rd_data 0, busy_vec[0] 0, rd_busy 0.
- Scoreboard:
  - sb_set r9 -> busy_vec[9] = 1 the next cycle
  - wr r9 -> busy_vec[9] = 0
  - simultaneous sb_set r9 and wr r9 = 0x55 -> busy_vec[9] stays 1 and mem[9] = 0x55.
- Deassert reset_n mid-stream with rd_en high and r3 busy -> rd_valid, busy_vec, and r3 read zero immediately; after release, the first read of r3 returns 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file definitions used by decode, issue, writeback and the
// register file itself.
package regfile_pkg;

  localparam int DEFAULT_DATA_W   = 64;
  localparam int DEFAULT_NUM_REGS = 32;
  localparam int DEFAULT_RD_PORTS = 2;
  localparam int REG_IDX_W        = $clog2(DEFAULT_NUM_REGS);

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;

endpackage : regfile_pkg

// File: rtl/regfile_read_port.sv
// One registered read port: write-first bypass, r0 forcing, and the
// valid/busy pipeline stage.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = REG_IDX_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rdEn,
  input  logic [ADDR_W-1:0] rdAddr,
  input  logic [DATA_W-1:0] memData,
  input  logic              busyNext,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  output logic [DATA_W-1:0] rdData,
  output logic              rdValid,
  output logic              rdBusy
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic              isZero;
  logic [DATA_W-1:0] dataNext;

  assign isZero = (rdAddr == ZERO_IDX);

  // NOTE: assign a default first so every path drives dataNext; no latch.
  always_comb begin
    dataNext = memData;
    if (isZero) begin
      dataNext = '0;
    end else if (wrEn && (wrAddr == rdAddr)) begin
      dataNext = wrData;
    end
  end

  // NOTE: non-blocking assignments for all flop state so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdData  <= '0;
      rdValid <= 1'b0;
      rdBusy  <= 1'b0;
    end else begin
      rdValid <= rdEn;
      if (rdEn) begin
        rdData <= dataNext;
        rdBusy <= busyNext && !isZero;
      end
    end
  end

endmodule : regfile_read_port

// File: rtl/regfile_scoreboard.sv
// Integer register file with N registered read ports, one write port and a
// per-register busy scoreboard for in-order hazard detection.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int BUS_DATA_WIDTH = DEFAULT_DATA_W,
  parameter  int NUM_REGS       = DEFAULT_NUM_REGS,
  parameter  int NUM_RD_PORTS   = DEFAULT_RD_PORTS,
  localparam int ADDR_W         = $clog2(NUM_REGS)
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [NUM_RD_PORTS-1:0]                rd_en,
  input  logic [NUM_RD_PORTS*ADDR_W-1:0]         rd_addr,
  output logic [NUM_RD_PORTS*BUS_DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD_PORTS-1:0]                rd_valid,
  output logic [NUM_RD_PORTS-1:0]                rd_busy,
  input  logic                                   wr_en,
  input  logic [ADDR_W-1:0]                      wr_addr,
  input  logic [BUS_DATA_WIDTH-1:0]              wr_data,
  input  logic                                   sb_set_en,
  input  logic [ADDR_W-1:0]                      sb_set_addr,
  output logic [NUM_REGS-1:0]                    busy_vec
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [BUS_DATA_WIDTH-1:0] regMem [NUM_REGS];
  logic [NUM_REGS-1:0]       busyQ;
  logic [NUM_REGS-1:0]       busyNext;

  // NOTE: the array is cleared by reset because software may read any
  // register before writing it; it is therefore built from flops, not SRAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regMem[i] <= '0;
      end
    end else if (wr_en && (wr_addr != ZERO_IDX)) begin
      regMem[wr_addr] <= wr_data;
    end
  end

  // Set is applied after clear so a newly issued producer keeps the register
  // pending while the previous producer retires.
  always_comb begin
    busyNext = busyQ;
    if (wr_en) begin
      busyNext[wr_addr] = 1'b0;
    end
    if (sb_set_en) begin
      busyNext[sb_set_addr] = 1'b1;
    end
    busyNext[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busyQ <= '0;
    end else begin
      busyQ <= busyNext;
    end
  end

  assign busy_vec = busyQ;

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd_port
    logic [ADDR_W-1:0] portAddr;

    assign portAddr = rd_addr[p*ADDR_W +: ADDR_W];

    regfile_read_port #(
      .DATA_W (BUS_DATA_WIDTH),
      .ADDR_W (ADDR_W)
    ) u_read_port (
      .clk      (clk),
      .reset_n  (reset_n),
      .rdEn     (rd_en[p]),
      .rdAddr   (portAddr),
      .memData  (regMem[portAddr]),
      .busyNext (busyNext[portAddr]),
      .wrEn     (wr_en),
      .wrAddr   (wr_addr),
      .wrData   (wr_data),
      .rdData   (rd_data[p*BUS_DATA_WIDTH +: BUS_DATA_WIDTH]),
      .rdValid  (rd_valid[p]),
      .rdBusy   (rd_busy[p])
    );
  end

endmodule : regfile_scoreboard

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (64-bit, 32 regs,
// 2 read ports).
module tb_regfile_scoreboard;

  localparam int DW = 64;
  localparam int NR = 32;
  localparam int NP = 2;
  localparam int AW = 5;

  logic              clk;
  logic              reset_n;
  logic [NP-1:0]     rd_en;
  logic [NP*AW-1:0]  rd_addr;
  logic [NP*DW-1:0]  rd_data;
  logic [NP-1:0]     rd_valid;
  logic [NP-1:0]     rd_busy;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              sb_set_en;
  logic [AW-1:0]     sb_set_addr;
  logic [NR-1:0]     busy_vec;

  int nChecks = 0;
  int nFails  = 0;

  regfile_scoreboard #(
    .BUS_DATA_WIDTH (DW),
    .NUM_REGS       (NR),
    .NUM_RD_PORTS   (NP)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_busy     (rd_busy),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .sb_set_en   (sb_set_en),
    .sb_set_addr (sb_set_addr),
    .busy_vec    (busy_vec)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en       = '0;
    rd_addr     = '0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    sb_set_en   = 1'b0;
    sb_set_addr = '0;
  endtask

  function automatic logic [DW-1:0] portData(input int p);
    return rd_data[p*DW +: DW];
  endfunction

  task automatic test_reset();
    idle();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    nChecks++;
    if ({rd_valid, rd_busy, busy_vec} !== '0 || rd_data !== '0) begin
      nFails++;
      $display("FAIL reset_outputs: valid=%b busy=%b busy_vec=%h data=%h required all zero",
               rd_valid, rd_busy, busy_vec, rd_data);
    end
    tick();
    tick();
    #2 reset_n = 1'b1;
    tick();
    for (int i = 0; i < NR; i++) begin
      rd_en   = 2'b11;
      rd_addr = {AW'(i), AW'(i)};
      tick();
      nChecks++;
      if (rd_valid !== 2'b11 || rd_data !== '0 || rd_busy !== 2'b00) begin
        nFails++;
        $display("FAIL reset_read_r%0d: valid=%b data=%h busy=%b required valid=11 data=0 busy=00",
                 i, rd_valid, rd_data, rd_busy);
      end
      rd_en = 2'b00;
      tick();
      nChecks++;
      if (rd_valid !== 2'b00) begin
        nFails++;
        $display("FAIL reset_valid_drop_r%0d: valid=%b required 00", i, rd_valid);
      end
    end
  endtask

  task automatic test_write_read();
    idle();
    wr_en   = 1'b1;
    wr_addr = 5'd5;
    wr_data = 64'hDEADBEEF_CAFEF00D;
    tick();
    idle();
    rd_en   = 2'b01;
    rd_addr = {5'd0, 5'd5};
    nChecks++;
    if (rd_valid[0] !== 1'b0) begin
      nFails++;
      $display("FAIL write_read_early_valid: valid=%b required 0", rd_valid[0]);
    end
    tick();
    nChecks++;
    if (rd_valid !== 2'b01 || portData(0) !== 64'hDEADBEEF_CAFEF00D) begin
      nFails++;
      $display("FAIL write_read_r5: valid=%b data=%h required valid=01 data=deadbeefcafef00d",
               rd_valid, portData(0));
    end
  endtask

  task automatic test_bypass();
    idle();
    wr_en   = 1'b1;
    wr_addr = 5'd7;
    wr_data = 64'h1234;
    rd_en   = 2'b11;
    rd_addr = {5'd7, 5'd7};
    tick();
    nChecks++;
    if (rd_valid !== 2'b11 || portData(0) !== 64'h1234 || portData(1) !== 64'h1234) begin
      nFails++;
      $display("FAIL bypass_r7: valid=%b p0=%h p1=%h required valid=11 p0=p1=1234",
               rd_valid, portData(0), portData(1));
    end
    idle();
    rd_addr = {5'd5, 5'd5};
    tick();
    nChecks++;
    if (rd_valid !== 2'b00 || portData(0) !== 64'h1234 || portData(1) !== 64'h1234) begin
      nFails++;
      $display("FAIL bypass_hold: valid=%b p0=%h p1=%h required valid=00 data held at 1234",
               rd_valid, portData(0), portData(1));
    end
  endtask

  task automatic test_reg_zero();
    idle();
    wr_en       = 1'b1;
    wr_addr     = 5'd0;
    wr_data     = 64'hFFFF;
    sb_set_en   = 1'b1;
    sb_set_addr = 5'd0;
    rd_en       = 2'b10;
    rd_addr     = {5'd0, 5'd0};
    tick();
    nChecks++;
    if (busy_vec[0] !== 1'b0 || portData(1) !== '0 || rd_busy[1] !== 1'b0) begin
      nFails++;
      $display("FAIL r0_same_cycle: busy_vec0=%b p1=%h rd_busy1=%b required 0,0,0",
               busy_vec[0], portData(1), rd_busy[1]);
    end
    idle();
    rd_en   = 2'b11;
    rd_addr = {5'd0, 5'd0};
    tick();
    nChecks++;
    if (rd_valid !== 2'b11 || rd_data !== '0 || rd_busy !== 2'b00 || busy_vec !== '0) begin
      nFails++;
      $display("FAIL r0_read: valid=%b data=%h busy=%b busy_vec=%h required 11,0,00,0",
               rd_valid, rd_data, rd_busy, busy_vec);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    sb_set_en   = 1'b1;
    sb_set_addr = 5'd9;
    rd_en       = 2'b10;
    rd_addr     = {5'd9, 5'd0};
    tick();
    nChecks++;
    if (busy_vec !== 32'h0000_0200 || rd_busy[1] !== 1'b1) begin
      nFails++;
      $display("FAIL sb_set_r9: busy_vec=%h rd_busy1=%b required 00000200,1", busy_vec, rd_busy[1]);
    end
    idle();
    wr_en   = 1'b1;
    wr_addr = 5'd9;
    wr_data = 64'hAA;
    rd_en   = 2'b01;
    rd_addr = {5'd0, 5'd9};
    tick();
    nChecks++;
    if (busy_vec !== '0 || rd_busy[0] !== 1'b0 || portData(0) !== 64'hAA) begin
      nFails++;
      $display("FAIL sb_clear_r9: busy_vec=%h rd_busy0=%b p0=%h required 0,0,aa",
               busy_vec, rd_busy[0], portData(0));
    end
    sb_set_en   = 1'b1;
    sb_set_addr = 5'd9;
    wr_data     = 64'h55;
    tick();
    nChecks++;
    if (busy_vec !== 32'h0000_0200 || rd_busy[0] !== 1'b1 || portData(0) !== 64'h55) begin
      nFails++;
      $display("FAIL sb_set_wins_r9: busy_vec=%h rd_busy0=%b p0=%h required 00000200,1,55",
               busy_vec, rd_busy[0], portData(0));
    end
    idle();
    rd_en   = 2'b01;
    rd_addr = {5'd0, 5'd9};
    tick();
    nChecks++;
    if (portData(0) !== 64'h55 || rd_busy[0] !== 1'b1 || busy_vec !== 32'h0000_0200) begin
      nFails++;
      $display("FAIL sb_mem_r9: p0=%h rd_busy0=%b busy_vec=%h required 55,1,00000200",
               portData(0), rd_busy[0], busy_vec);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp1;
    idle();
    for (int i = 0; i < 4; i++) begin
      wr_en   = 1'b1;
      wr_addr = AW'(10 + i);
      wr_data = 64'h1000 + 64'(i);
      rd_en   = 2'b11;
      rd_addr = {(i == 0) ? 5'd5 : AW'(9 + i), AW'(10 + i)};
      exp1    = (i == 0) ? 64'hDEADBEEF_CAFEF00D : 64'h1000 + 64'(i - 1);
      tick();
      nChecks++;
      if (portData(0) !== 64'h1000 + 64'(i) || portData(1) !== exp1 || rd_valid !== 2'b11) begin
        nFails++;
        $display("FAIL b2b_%0d: p0=%h p1=%h valid=%b required p0=%h p1=%h valid=11",
                 i, portData(0), portData(1), rd_valid, 64'h1000 + 64'(i), exp1);
      end
    end
    idle();
    sb_set_en   = 1'b1;
    sb_set_addr = 5'd20;
    wr_en       = 1'b1;
    wr_addr     = 5'd9;
    wr_data     = 64'h99;
    tick();
    nChecks++;
    if (busy_vec !== 32'h0010_0000) begin
      nFails++;
      $display("FAIL b2b_set_clear_split: busy_vec=%h required 00100000", busy_vec);
    end
    idle();
    wr_en   = 1'b1;
    wr_addr = 5'd20;
    wr_data = 64'h20;
    tick();
    nChecks++;
    if (busy_vec !== '0) begin
      nFails++;
      $display("FAIL b2b_clear_r20: busy_vec=%h required 0", busy_vec);
    end
  endtask

  task automatic test_reset_midstream();
    idle();
    wr_en   = 1'b1;
    wr_addr = 5'd3;
    wr_data = 64'h333;
    tick();
    idle();
    sb_set_en   = 1'b1;
    sb_set_addr = 5'd3;
    tick();
    idle();
    rd_en   = 2'b11;
    rd_addr = {5'd3, 5'd3};
    tick();
    nChecks++;
    if (busy_vec !== 32'h0000_0008 || rd_valid !== 2'b11 || portData(0) !== 64'h333 || rd_busy !== 2'b11) begin
      nFails++;
      $display("FAIL midrst_before: busy_vec=%h valid=%b p0=%h busy=%b required 00000008,11,333,11",
               busy_vec, rd_valid, portData(0), rd_busy);
    end
    #2 reset_n = 1'b0;
    #1;
    nChecks++;
    if (rd_valid !== 2'b00 || busy_vec !== '0 || rd_data !== '0 || rd_busy !== 2'b00) begin
      nFails++;
      $display("FAIL midrst_async_clear: valid=%b busy_vec=%h data=%h busy=%b required all zero",
               rd_valid, busy_vec, rd_data, rd_busy);
    end
    #2 reset_n = 1'b1;
    rd_en   = 2'b01;
    rd_addr = {5'd0, 5'd3};
    tick();
    nChecks++;
    if (rd_valid !== 2'b01 || portData(0) !== '0 || rd_busy[0] !== 1'b0) begin
      nFails++;
      $display("FAIL midrst_first_read_r3: valid=%b p0=%h busy0=%b required 01,0,0",
               rd_valid, portData(0), rd_busy[0]);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_reg_zero();
    test_scoreboard();
    test_back_to_back();
    test_reset_midstream();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule : tb_regfile_scoreboard
